// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared game-state encodings and playfield geometry
package breakout_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_PLAY = 2'd1,
    GS_WIN  = 2'd2,
    GS_END  = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    BS_HOLD,
    BS_MOVE,
    BS_DEAD,
    BS_DONE
  } ball_state_t;

  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int BALL_SIZE      = 8;
  localparam int PADDLE_Y       = 440;
  localparam int PADDLE_W       = 80;
  localparam int SPEED          = 2;
  localparam int BRICK_COUNT    = 40;
  localparam int LIVES_INIT     = 3;
  localparam int LAUNCH_FRAMES  = 60;
  localparam int RESPAWN_FRAMES = 30;

  // Derived geometry: ball parked centred on the paddle, paddle starts centred on screen.
  localparam int X_MAX      = SCREEN_W - BALL_SIZE;
  localparam int Y_MAX      = SCREEN_H;
  localparam int MISS_Y     = SCREEN_H - BALL_SIZE;
  localparam int HOLD_X_OFS = (PADDLE_W - BALL_SIZE) / 2;
  localparam int HOLD_Y     = PADDLE_Y - BALL_SIZE;
  localparam int RESET_X    = (SCREEN_W - PADDLE_W) / 2 + HOLD_X_OFS;

endpackage

// File: rtl/ball_axis_step.sv
// rtl/ball_axis_step.sv - one axis of ball motion: brick flip, low-wall/high-side bounce, clamped step
module ball_axis_step
  import breakout_pkg::*;
#(
  parameter int MAX_POS = X_MAX
) (
  input  logic [9:0] pos,
  input  logic       dir,
  input  logic       flip,
  input  logic       step,
  input  logic       hi_hit,
  output logic [9:0] next_pos,
  output logic       next_dir
);

  logic [10:0] pos_ext;
  logic [10:0] fwd;
  logic [9:0]  back;

  assign pos_ext = {1'b0, pos};
  assign fwd     = pos_ext + 11'(SPEED);
  assign back    = pos - 10'(SPEED);

  // dir: 1 = increasing coordinate. A brick flip applies on any cycle; bounces only on a step.
  always_comb begin
    next_dir = dir ^ flip;
    next_pos = pos;
    if (step) begin
      if (pos_ext <= 11'(SPEED)) begin
        next_dir = 1'b1;
      end else if (hi_hit) begin
        next_dir = 1'b0;
      end
      if (next_dir) begin
        next_pos = (fwd > 11'(MAX_POS)) ? 10'(MAX_POS) : fwd[9:0];
      end else begin
        next_pos = (pos_ext < 11'(SPEED)) ? 10'd0 : back;
      end
    end
  end

endmodule

// File: rtl/breakout_ball_engine.sv
// rtl/breakout_ball_engine.sv - ball FSM, lives/bricks bookkeeping and win/lose pulses
module breakout_ball_engine
  import breakout_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] game_state,
  input  logic       game_reset,
  input  logic       frame_tick,
  input  logic [9:0] paddle_x,
  input  logic       brick_hit,
  input  logic       brick_hit_vert,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] lives,
  output logic [5:0] bricks_left,
  output logic       lose_sig,
  output logic       win_sig
);

  ball_state_t state;
  logic [5:0]  frame_cnt;
  logic        dx, dy;
  logic        flipped_x, flipped_y;

  logic        tick, in_move, step, flip_x, flip_y, miss, last_brick;
  logic        hi_x, hi_y, next_dx, next_dy;
  logic [9:0]  next_x, next_y, hold_x;
  logic [10:0] x_ext, y_ext, px_ext, hold_sum;

  assign tick       = frame_tick && (game_state_t'(game_state) == GS_PLAY);
  assign in_move    = (state == BS_MOVE);
  assign step       = in_move && tick;
  assign flip_x     = in_move && brick_hit && !brick_hit_vert && !flipped_x;
  assign flip_y     = in_move && brick_hit && brick_hit_vert && !flipped_y;
  assign last_brick = in_move && brick_hit && (bricks_left == 6'd1);

  assign x_ext    = {1'b0, ball_x};
  assign y_ext    = {1'b0, ball_y};
  assign px_ext   = {1'b0, paddle_x};
  assign hold_sum = px_ext + 11'(HOLD_X_OFS);
  assign hold_x   = (hold_sum > 11'(X_MAX)) ? 10'(X_MAX) : hold_sum[9:0];
  assign miss     = step && (y_ext >= 11'(MISS_Y));

  // The y "high side" is the paddle top face, not a wall: the floor is a miss.
  assign hi_x = (x_ext + 11'(BALL_SIZE)) >= 11'(SCREEN_W - SPEED);
  assign hi_y = ((y_ext + 11'(BALL_SIZE)) >= 11'(PADDLE_Y))
             && ((y_ext + 11'(BALL_SIZE)) < 11'(PADDLE_Y + SPEED))
             && ((x_ext + 11'(BALL_SIZE)) > px_ext)
             && (x_ext < (px_ext + 11'(PADDLE_W)));

  ball_axis_step #(.MAX_POS(X_MAX)) u_axis_x (
    .pos      (ball_x),
    .dir      (dx),
    .flip     (flip_x),
    .step     (step),
    .hi_hit   (hi_x),
    .next_pos (next_x),
    .next_dir (next_dx)
  );

  ball_axis_step #(.MAX_POS(Y_MAX)) u_axis_y (
    .pos      (ball_y),
    .dir      (dy),
    .flip     (flip_y),
    .step     (step),
    .hi_hit   (hi_y),
    .next_pos (next_y),
    .next_dir (next_dy)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= BS_HOLD;
      frame_cnt   <= '0;
      dx          <= 1'b1;
      dy          <= 1'b0;
      flipped_x   <= 1'b0;
      flipped_y   <= 1'b0;
      ball_x      <= 10'(RESET_X);
      ball_y      <= 10'(HOLD_Y);
      lives       <= 2'(LIVES_INIT);
      bricks_left <= 6'(BRICK_COUNT);
      lose_sig    <= 1'b0;
      win_sig     <= 1'b0;
    end else if (game_reset) begin
      state       <= BS_HOLD;
      frame_cnt   <= '0;
      dx          <= 1'b1;
      dy          <= 1'b0;
      flipped_x   <= 1'b0;
      flipped_y   <= 1'b0;
      ball_x      <= 10'(RESET_X);
      ball_y      <= 10'(HOLD_Y);
      lives       <= 2'(LIVES_INIT);
      bricks_left <= 6'(BRICK_COUNT);
      lose_sig    <= 1'b0;
      win_sig     <= 1'b0;
    end else begin
      lose_sig <= 1'b0;
      win_sig  <= 1'b0;
      unique case (state)
        BS_HOLD: begin
          ball_x <= hold_x;
          ball_y <= 10'(HOLD_Y);
          if (tick) begin
            if (frame_cnt == 6'(LAUNCH_FRAMES - 1)) begin
              state     <= BS_MOVE;
              frame_cnt <= '0;
              dx        <= 1'b1;
              dy        <= 1'b0;
              flipped_x <= 1'b0;
              flipped_y <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + 6'd1;
            end
          end
        end
        BS_MOVE: begin
          // A hit on the tick cycle belongs to the frame that is closing.
          flipped_x <= tick ? 1'b0 : (flipped_x | flip_x);
          flipped_y <= tick ? 1'b0 : (flipped_y | flip_y);
          if (brick_hit && bricks_left != 6'd0) begin
            bricks_left <= bricks_left - 6'd1;
          end
          if (last_brick) begin
            win_sig <= 1'b1;
            state   <= BS_DONE;
          end else if (miss) begin
            if (lives > 2'd1) begin
              lives     <= lives - 2'd1;
              state     <= BS_DEAD;
              frame_cnt <= '0;
            end else begin
              lives    <= 2'd0;
              lose_sig <= 1'b1;
              state    <= BS_DONE;
            end
          end else begin
            ball_x <= next_x;
            ball_y <= next_y;
            dx     <= next_dx;
            dy     <= next_dy;
          end
        end
        BS_DEAD: begin
          if (tick) begin
            if (frame_cnt == 6'(RESPAWN_FRAMES - 1)) begin
              state     <= BS_HOLD;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + 6'd1;
            end
          end
        end
        BS_DONE: ;
      endcase
    end
  end

endmodule
